// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  typedef enum logic {
    StIdle = ST_IDLE,
    StBusy = ST_BUSY
  } arb_state_e;

endpackage

// File: rtl/decoder3to8.sv
// 3-to-8 binary-to-one-hot decoder.
module decoder3to8
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] sel,
  output logic [N_REQ-1:0] y
);

  always_comb begin
    y      = '0;
    y[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with hold-until-release handshake and hold-time watchdog.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_W   = 8,
  parameter int unsigned MAX_HOLD = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic              WatchdogEn = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HoldLast   = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic              owner_gone;
  logic              hold_expired;
  logic [N_REQ-1:0]  gnt_raw;

  // First set bit of r, scanning p, p+1, ... p+7 with 3-bit wrap. The downward loop lets the
  // smallest offset overwrite any later candidate.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] cand;
    rr_pick = p;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = p + IDX_W'(k);
      if (r[cand]) rr_pick = cand;
    end
  endfunction

  assign owner_gone   = ~req[idx_q];
  assign hold_expired = WatchdogEn && (cnt_q == HoldLast);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          idx_d   = rr_pick(req, ptr_q);
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (rel || owner_gone || hold_expired) begin
          state_d   = StIdle;
          ptr_d     = idx_q + IDX_W'(1);
          cnt_d     = '0;
          // A watchdog hit that coincides with a normal release is not reported.
          timeout_d = hold_expired && !rel && !owner_gone;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  decoder3to8 u_dec (
    .sel (idx_q),
    .y   (gnt_raw)
  );

  assign gnt_valid = (state_q == StBusy);
  assign gnt_idx   = idx_q;
  assign timeout   = timeout_q;
  assign gnt       = gnt_raw & {N_REQ{gnt_valid}};

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: behavioural model checked every cycle plus literal expectations.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_vec = 0;
  int n_err = 0;

  // Model state: who holds the resource, how many cycles it has held it, and who was last served.
  bit m_busy    = 1'b0;
  int m_owner   = 0;
  int m_ptr     = 0;
  int m_held    = 0;
  bit m_timeout = 1'b0;

  rr_arbiter8 #(
    .HOLD_W   (8),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rel       (rel),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  initial begin
    int  best;
    int  cand;
    bit  cap;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy    = 1'b0;
        m_owner   = 0;
        m_ptr     = 0;
        m_held    = 0;
        m_timeout = 1'b0;
      end else if (!m_busy) begin
        m_timeout = 1'b0;
        best = -1;
        for (int d = 0; d < 8; d++) begin
          cand = (m_ptr + d) % 8;
          if (req[cand] && best < 0) best = cand;
        end
        if (best >= 0) begin
          m_busy  = 1'b1;
          m_owner = best;
          m_held  = 1;
        end
      end else begin
        cap = (MAX_HOLD != 0) && (m_held >= MAX_HOLD);
        if (rel || !req[m_owner] || cap) begin
          m_timeout = cap && !rel && req[m_owner];
          m_busy    = 1'b0;
          m_ptr     = (m_owner + 1) % 8;
        end else begin
          m_timeout = 1'b0;
          m_held++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model gnt", gnt, m_busy ? (8'h01 << m_owner) : 8'h00);
    chk("model gnt_idx", {5'b0, gnt_idx}, 8'(m_owner));
    chk("model gnt_valid", {7'b0, gnt_valid}, {7'b0, m_busy});
    chk("model timeout", {7'b0, timeout}, {7'b0, m_timeout});
  end

  initial begin
    #200000;
    $display("FAIL global time limit at %0t: got running, required finished", $time);
    $fatal(1, "time limit");
  end

  task automatic nc();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    rel   = 1'b0;
    repeat (3) nc();
    rst_n = 1'b1;
    chk("reset gnt", gnt, 8'h00);
    chk("reset gnt_idx", {5'b0, gnt_idx}, 8'h00);
    chk("reset gnt_valid", {7'b0, gnt_valid}, 8'h00);
    chk("reset timeout", {7'b0, timeout}, 8'h00);

    // Round-robin sweep with every requester active.
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      nc(); chk("rr grant", gnt, 8'h01 << (k % 8));
      nc(); chk("rr hold", gnt, 8'h01 << (k % 8)); rel = 1'b1;
      nc(); chk("rr bubble", gnt, 8'h00); rel = 1'b0;
      if (k == 8) req = 8'h00;
    end

    // Serve 5 so the pointer sits at 6, then check wrap and skip.
    req = 8'h20;
    nc(); chk("serve 5", gnt, 8'h20); rel = 1'b1;
    nc(); chk("serve 5 bubble", gnt, 8'h00); rel = 1'b0; req = 8'h05;
    nc(); chk("wrap to 0", gnt, 8'h01); rel = 1'b1;
    nc(); chk("wrap bubble", gnt, 8'h00); rel = 1'b0;
    nc(); chk("skip to 2", gnt, 8'h04); rel = 1'b1;
    nc(); rel = 1'b0; req = 8'h00;

    // Owner 3 withdraws; next grant goes to 6, not 1.
    req = 8'h4A;
    nc(); chk("owner 3", gnt, 8'h08); req = 8'h42;
    nc(); chk("withdraw gnt", gnt, 8'h00);
    chk("withdraw valid", {7'b0, gnt_valid}, 8'h00);
    chk("withdraw timeout", {7'b0, timeout}, 8'h00);
    nc(); chk("after withdraw", gnt, 8'h40); rel = 1'b1;
    nc(); rel = 1'b0; req = 8'h00;

    // Watchdog: idx 4 held with no release.
    req = 8'h10;
    for (int c = 0; c < 4; c++) begin
      nc(); chk("wd hold", gnt, 8'h10); chk("wd no timeout", {7'b0, timeout}, 8'h00);
    end
    nc(); chk("wd bubble", gnt, 8'h00); chk("wd timeout", {7'b0, timeout}, 8'h01);
    nc(); chk("wd regrant", gnt, 8'h10); chk("wd pulse end", {7'b0, timeout}, 8'h00);

    // rel on the 4th hold cycle coincides with the watchdog: plain release.
    nc(); chk("co hold 2", gnt, 8'h10);
    nc(); chk("co hold 3", gnt, 8'h10);
    nc(); chk("co hold 4", gnt, 8'h10); rel = 1'b1;
    nc(); chk("co released", gnt, 8'h00); chk("co no timeout", {7'b0, timeout}, 8'h00);
    rel = 1'b0; req = 8'h00;

    // rel in IDLE is ignored and not remembered.
    nc(); rel = 1'b1;
    nc(); chk("idle rel gnt", gnt, 8'h00); chk("idle rel idx", {5'b0, gnt_idx}, 8'h04);
    rel = 1'b0; req = 8'h40;
    nc(); chk("after idle rel", gnt, 8'h40);
    nc(); chk("rel not stored", gnt, 8'h40); req = 8'hFF;

    // Asynchronous reset mid-grant.
    #2 rst_n = 1'b0;
    #1;
    chk("async rst gnt", gnt, 8'h00);
    chk("async rst idx", {5'b0, gnt_idx}, 8'h00);
    chk("async rst valid", {7'b0, gnt_valid}, 8'h00);
    nc(); nc(); rst_n = 1'b1;
    nc(); chk("post rst grant", gnt, 8'h01); rel = 1'b1;
    nc(); rel = 1'b0; req = 8'h00;
    nc(); nc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource between 8 requesters.
- The winning index drives the existing 3-to-8 decoder to produce a one-hot grant vector.
- Enforces fairness, a hold-until-release handshake, and an optional hold-time watchdog.
- Sits between 8 client blocks and a shared bus or peripheral; its one-hot output is the resource select.

Parameters:
HOLD_W, 8, width of the hold counter.
MAX_HOLD, 100, maximum cycles a grant may be held before forced release; 0 disables the watchdog.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  8  request vector; bit i is requester i; level-sensitive.
rel  input  1  release pulse from the current owner; ignored when no grant is active.
gnt  output  8  one-hot grant, equal to the decoder output for gnt_idx while gnt_valid = 1; otherwise 8'h00.
gnt_idx  output  3  index of the current or last grant.
gnt_valid  output  1  high while a grant is active.
timeout  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State IDLE.
  - gnt = 8'h00, gnt_idx = 3'd0, gnt_valid = 0, timeout = 0.
  - Priority pointer ptr = 3'd0; hold counter = 0.
- States: IDLE, BUSY. Encoding is a shared localparam.
- IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, ..., ptr+7 (mod 8).
  - Register the winner into gnt_idx, set gnt_valid = 1, go to BUSY.
  - Grant is visible one cycle after req is sampled high.
  - If req == 0, stay in IDLE and keep all outputs unchanged except gnt = 0.
- BUSY:
  - gnt = one-hot of gnt_idx; the hold counter increments every cycle starting from 0.
  - Release conditions, evaluated each edge:
    - (a) rel = 1;
    - (b) req[gnt_idx] = 0, i.e. the requester withdrew;
    - (c) MAX_HOLD != 0 and counter == MAX_HOLD-1.
  - On release: gnt_valid <= 0, ptr <= gnt_idx+1 (3-bit wrap, 7 -> 0), counter <= 0, return to IDLE.
  - Condition (c) alone also pulses timeout = 1 for that cycle.
  - If (c) coincides with (a) or (b), it is a normal release: timeout = 0.
- Guaranteed bubble: at least one IDLE cycle (gnt = 0) between consecutive grants, so grants never overlap.
- Fairness:
  - The requester just served has the lowest priority on the next arbitration.
  - With all 8 requesting continuously, grant order is 0, 1, ..., 7, 0, ...
  - Each waiting requester is served within 7 grants.
- rel while IDLE is ignored; rel is not stored.
- Request changes during BUSY do not preempt; only the owner's req bit affects the grant.
- Reset mid-grant: gnt drops to 0 immediately (asynchronous), ptr returns to 0, and a pending timeout is discarded.
- Watchdog arithmetic:
  - The counter is HOLD_W bits, unsigned.
  - MAX_HOLD must be < 2^HOLD_W; the counter saturates rather than wrapping.
- gnt is combinational from registered gnt_idx and gnt_valid (decoder output AND gnt_valid), so it is glitch-free relative to clk.

Decomposition:
- Package arb_pkg holds:
  - state localparams ST_IDLE = 1'b0, ST_BUSY = 1'b1;
  - N_REQ = 8, IDX_W = 3.
- Sub-module: instantiate the existing decoder3to8 (sel = gnt_idx, y = raw one-hot), gated with gnt_valid.
- The rotating priority search is implemented as a function inside rr_arbiter8; it is not a separate module.

Test Plan:
- Reset: assert rst_n = 0 mid-sim with req = 8'hFF -> gnt = 8'h00, gnt_valid = 0, gnt_idx = 0 immediately. First grant after release of reset is idx 0 (gnt = 8'h01) one cycle after req is sampled.
- Round-robin: req = 8'hFF held, rel pulsed 2 cycles after each grant -> gnt sequence 01, 02, 04, ..., 80, 01, with gnt = 00 for exactly one cycle between grants.
- Pointer wrap and skip: ptr = 6 (after granting 5), req = 8'b0000_0101 -> grant idx 0 (gnt = 01), then idx 2 (gnt = 04).
- Withdrawal: owner idx 3 drops req[3] with no rel -> gnt_valid = 0 next edge, timeout = 0, next grant skips to the next set bit after 3.
- Watchdog: MAX_HOLD = 4, req = 8'h10 held, no rel -> gnt = 8'h10 for exactly 4 cycles, then timeout = 1 for one cycle. Re-grant of idx 4 after the bubble.
- Coincidence: with MAX_HOLD = 4, pulse rel on the 4th hold cycle -> release with timeout = 0. Also confirm rel pulsed in IDLE produces no state change.
